// File: rtl/mul_seq.sv
// Multi-cycle unsigned multiplier: one LIMB_WIDTH x LIMB_WIDTH partial product per clock.
// Define MUL_SEQ_SIGNED_EN to treat the operands as two's complement.
module mul_seq #(
  parameter int DATA_WIDTH = 128,
  parameter int LIMB_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     dat1,
  input  logic [DATA_WIDTH-1:0]     dat2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   product,
  output logic                      busy
);

  localparam int LW_SAFE   = (LIMB_WIDTH < 1) ? 1 : LIMB_WIDTH;
  localparam int N         = (DATA_WIDTH / LW_SAFE < 1) ? 1 : DATA_WIDTH / LW_SAFE;
  localparam int CNT_WIDTH = (N > 1) ? $clog2(N) : 1;
  localparam int PW        = 2 * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(N - 1);

  if (LIMB_WIDTH < 1 || (DATA_WIDTH % LW_SAFE) != 0) begin : g_bad_cfg
    $error("mul_seq: DATA_WIDTH must be a positive multiple of LIMB_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]          acc_q, acc_d, product_q, product_d;
  logic                   out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]   i_q, i_d, j_q, j_d;
  logic [DATA_WIDTH-1:0]  op1, op2;
  logic [PW-1:0]          acc_sum, result;

  logic [LW_SAFE-1:0] a_limbs [N];
  logic [LW_SAFE-1:0] b_limbs [N];
  for (genvar gi = 0; gi < N; gi++) begin : g_limb
    assign a_limbs[gi] = a_q[gi*LW_SAFE +: LW_SAFE];
    assign b_limbs[gi] = b_q[gi*LW_SAFE +: LW_SAFE];
  end

  logic [2*LW_SAFE-1:0] pp;
  logic [PW-1:0]        pp_ext;
  logic [31:0]          shamt;
  assign pp      = a_limbs[i_q] * b_limbs[j_q];
  assign pp_ext  = PW'(pp);
  assign shamt   = LW_SAFE * (32'(i_q) + 32'(j_q));
  assign acc_sum = acc_q + (pp_ext << shamt);

`ifdef MUL_SEQ_SIGNED_EN
  // Latch magnitudes; the most-negative value maps to 2^(DATA_WIDTH-1) unsigned.
  logic sign_q, sign_d;
  assign op1    = dat1[DATA_WIDTH-1] ? -dat1 : dat1;
  assign op2    = dat2[DATA_WIDTH-1] ? -dat2 : dat2;
  assign result = sign_q ? -acc_sum : acc_sum;
`else
  assign op1    = dat1;
  assign op2    = dat2;
  assign result = acc_sum;
`endif

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    i_d         = i_q;
    j_d         = j_q;
`ifdef MUL_SEQ_SIGNED_EN
    sign_d      = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = op1;
          b_d     = op2;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
`ifdef MUL_SEQ_SIGNED_EN
          sign_d  = dat1[DATA_WIDTH-1] ^ dat2[DATA_WIDTH-1];
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = i_q + CNT_WIDTH'(1);
        end else begin
          j_d = j_q + CNT_WIDTH'(1);
        end
        if (i_q == LAST && j_q == LAST) begin
          product_d   = result;
          out_valid_d = 1'b1;
          i_d         = '0;
          j_d         = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
`ifdef MUL_SEQ_SIGNED_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      i_q         <= i_d;
      j_q         <= j_d;
`ifdef MUL_SEQ_SIGNED_EN
      sign_q      <= sign_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: expected products queued at accept, popped at out_valid.
module tb_mul_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] dat1, dat2;
  logic [255:0] product;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  logic [255:0] exp_q[$];

  mul_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dat1(dat1), .dat2(dat2), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [255:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
`ifdef MUL_SEQ_SIGNED_EN
    logic [255:0] ea, eb;
    ea = {{128{a[127]}}, a};
    eb = {{128{b[127]}}, b};
    return ea * eb;
`else
    return {128'b0, a} * {128'b0, b};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands and hold in_valid until the accepting edge.
  task automatic send(input logic [127:0] a, input logic [127:0] b, input bit keep_valid);
    int n = 0;
    dat1 = a;
    dat2 = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check("accept_timeout", 256'(n), 256'(0));
    tick();
    acc_cyc = cyc;
    exp_q.push_back(ref_mul(a, b));
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input int lat);
    int n = 0;
    logic [255:0] e;
    while (!out_valid && n < 200) begin tick(); n++; end
    check({tag, "_lat"}, 256'(cyc - acc_cyc), 256'(lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_prod"}, product, e);
  endtask

  initial begin
    logic [255:0] held;
    logic [127:0] ones;
    int last_acc;
    ones = '1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dat1 = '0; dat2 = '0;
    tick(); tick();
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_product", product, 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 256'(in_ready), 256'(1));

    // 1: all-ones squared
    out_ready = 1'b1;
    send(ones, ones, 1'b0);
    recv("t1_ones", 16);
`ifndef MUL_SEQ_SIGNED_EN
    check("t1_const", product, {{127{1'b1}}, 1'b0, 127'b0, 1'b1});
`endif
    tick();
    check("t1_drop_valid", 256'(out_valid), 256'(0));
    check("t1_in_ready", 256'(in_ready), 256'(1));

    // 2: limb-aligned powers of two, zero operand
    send(128'(1) << 32, 128'(1) << 96, 1'b0);
    recv("t2_pow2", 16);
    check("t2_pow2_const", product, 256'(1) << 128);
    send(128'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    recv("t2_zero", 16);
    check("t2_zero_const", product, 256'(0));
    tick();

    // 3: back-pressure in DONE with new operands offered
    out_ready = 1'b0;
    send(128'd7, 128'd9, 1'b0);
    recv("t3", 16);
    held = 256'd63;
    dat1 = 128'd11; dat2 = 128'd13; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3_hold_valid", 256'(out_valid), 256'(1));
      check("t3_hold_prod", product, held);
      check("t3_hold_in_ready", 256'(in_ready), 256'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t3_release_valid", 256'(out_valid), 256'(0));
    check("t3_release_in_ready", 256'(in_ready), 256'(1));
    check("t3_release_busy", 256'(busy), 256'(0));

    // 4: reset in the 7th CALC cycle
    send(ones, 128'd12345, 1'b0);
    for (int k = 0; k < 6; k++) tick();
    check("t4_busy_before", 256'(busy), 256'(1));
    rst = 1'b1;
    #1;
    check("t4_rst_valid", 256'(out_valid), 256'(0));
    check("t4_rst_product", product, 256'(0));
    check("t4_rst_busy", 256'(busy), 256'(0));
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check("t4_in_ready", 256'(in_ready), 256'(1));
    send(128'd3, 128'd5, 1'b0);
    recv("t4_after", 16);
    check("t4_const", product, 256'd15);
    tick();

    // 5: signed/unsigned interpretation of all-ones
    send(ones, 128'd2, 1'b0);
    recv("t5_a", 16);
`ifdef MUL_SEQ_SIGNED_EN
    check("t5_a_const", product, ~256'd1);
    tick();
    send(128'(1) << 127, ones, 1'b0);
    recv("t5_b", 16);
    check("t5_b_const", product, 256'(1) << 127);
`else
    check("t5_a_const", product, (256'(1) << 129) - 256'd2);
`endif
    tick();

    // 6: back-to-back with in_valid held high
    last_acc = 0;
    for (int k = 0; k < 3; k++) begin
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      if (k > 0) check("t6_interval", 256'(acc_cyc - last_acc), 256'(18));
      last_acc = acc_cyc;
      recv("t6", 16);
    end
    in_valid = 1'b0;
    tick();
    check("t6_queue_empty", 256'(exp_q.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
